// File: rtl/pipeline_control_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_control_pkg
// Shared encodings and control-bundle layout for the 5-stage RISC-V pipeline
// controller. The field widths here are the same ones the main decoder drives.
// -----------------------------------------------------------------------------
package pipeline_control_pkg;

  // Control-bundle field widths (shared with main_decoder)
  localparam int RESULTSRC_W = 2;
  localparam int ALUOP_W     = 2;
  localparam int FWD_W       = 2;

  // ResultSrc encodings
  localparam logic [RESULTSRC_W-1:0] RES_ALU = 2'b00;
  localparam logic [RESULTSRC_W-1:0] RES_MEM = 2'b01;
  localparam logic [RESULTSRC_W-1:0] RES_PC4 = 2'b11;

  // Forwarding select encodings
  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  // Control bundle carried from decode into execute
  typedef struct packed {
    logic                   reg_write;
    logic                   mem_write;
    logic                   alu_src;
    logic                   branch;
    logic                   jump;
    logic [RESULTSRC_W-1:0] result_src;
    logic [ALUOP_W-1:0]     alu_op;
  } ctrl_e_t;

  // All-zero bundle: no register write, no memory write, no redirect
  localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipeline_control_forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
// Combinational ALU operand forwarding selects for the execute stage.
// A producer in MEM wins over one in WB; x0 is never forwarded.
//
// Ports:
//   i_rs1_e, i_rs2_e   execute-stage source register addresses
//   i_rd_m, i_rd_w     destination addresses in MEM / WB
//   i_reg_write_m/_w   register write enables in MEM / WB
//   o_forward_a/_b     operand select: FWD_RF, FWD_WB or FWD_MEM
// -----------------------------------------------------------------------------
module forward_unit
  import pipeline_control_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs1_e,
  input  logic [REG_AW-1:0] i_rs2_e,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_reg_write_m,
  input  logic              i_reg_write_w,
  output logic [FWD_W-1:0]  o_forward_a,
  output logic [FWD_W-1:0]  o_forward_b
);

  logic w_m_valid;
  logic w_w_valid;

  // A stage is a usable forwarding source only if it writes a non-zero register
  assign w_m_valid = i_reg_write_m && (i_rd_m != '0);
  assign w_w_valid = i_reg_write_w && (i_rd_w != '0);

  always_comb begin
    o_forward_a = FWD_RF;
    if (w_m_valid && (i_rd_m == i_rs1_e)) begin
      o_forward_a = FWD_MEM;
    end else if (w_w_valid && (i_rd_w == i_rs1_e)) begin
      o_forward_a = FWD_WB;
    end
  end

  always_comb begin
    o_forward_b = FWD_RF;
    if (w_m_valid && (i_rd_m == i_rs2_e)) begin
      o_forward_b = FWD_MEM;
    end else if (w_w_valid && (i_rd_w == i_rs2_e)) begin
      o_forward_b = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// -----------------------------------------------------------------------------
// pipeline_control
// Central controller for the 5-stage RISC-V pipeline. Pipelines the decoded
// control bundle and register addresses through E/M/W, detects load-use
// hazards, generates stall/flush from the execute-stage branch/jump
// resolution, produces forwarding selects, and keeps saturating stall/flush
// event counters.
//
// Ports:
//   clk, reset                   core clock, synchronous active-high reset
//   *D                           decode-stage control bundle and reg fields
//   ZeroE                        ALU zero flag from execute
//   StallF/StallD                hold PC / IF-ID register
//   FlushD/FlushE                clear IF-ID / ID-EX register
//   PCSrcE                       take branch/jump target
//   ForwardAE/ForwardBE          ALU operand forwarding selects
//   *E, *M, *W                   pipelined control and register addresses
//   stall_cnt, flush_cnt         saturating performance counters
// -----------------------------------------------------------------------------
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  // decode stage
  input  logic                   RegWriteD,
  input  logic                   MemWriteD,
  input  logic                   ALUSrcD,
  input  logic                   BranchD,
  input  logic                   JumpD,
  input  logic [RESULTSRC_W-1:0] ResultSrcD,
  input  logic [ALUOP_W-1:0]     ALUOpD,
  input  logic [REG_AW-1:0]      Rs1D,
  input  logic [REG_AW-1:0]      Rs2D,
  input  logic [REG_AW-1:0]      RdD,
  input  logic                   ZeroE,
  // hazard controls
  output logic                   StallF,
  output logic                   StallD,
  output logic                   FlushD,
  output logic                   FlushE,
  output logic                   PCSrcE,
  output logic [FWD_W-1:0]       ForwardAE,
  output logic [FWD_W-1:0]       ForwardBE,
  // execute stage
  output logic                   RegWriteE,
  output logic                   MemWriteE,
  output logic                   ALUSrcE,
  output logic                   BranchE,
  output logic                   JumpE,
  output logic [RESULTSRC_W-1:0] ResultSrcE,
  output logic [ALUOP_W-1:0]     ALUOpE,
  // memory stage
  output logic                   RegWriteM,
  output logic                   MemWriteM,
  output logic [RESULTSRC_W-1:0] ResultSrcM,
  // writeback stage
  output logic                   RegWriteW,
  output logic [RESULTSRC_W-1:0] ResultSrcW,
  // pipelined register addresses
  output logic [REG_AW-1:0]      Rs1E,
  output logic [REG_AW-1:0]      Rs2E,
  output logic [REG_AW-1:0]      RdE,
  output logic [REG_AW-1:0]      RdM,
  output logic [REG_AW-1:0]      RdW,
  // performance counters
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // execute-stage register
  ctrl_e_t                r_ctrl_e;
  logic [REG_AW-1:0]      r_rs1_e;
  logic [REG_AW-1:0]      r_rs2_e;
  logic [REG_AW-1:0]      r_rd_e;

  // memory-stage register
  logic                   r_reg_write_m;
  logic                   r_mem_write_m;
  logic [RESULTSRC_W-1:0] r_result_src_m;
  logic [REG_AW-1:0]      r_rd_m;

  // writeback-stage register
  logic                   r_reg_write_w;
  logic [RESULTSRC_W-1:0] r_result_src_w;
  logic [REG_AW-1:0]      r_rd_w;

  // counters
  logic [CNT_W-1:0]       r_stall_cnt;
  logic [CNT_W-1:0]       r_flush_cnt;

  ctrl_e_t                w_ctrl_d;
  logic                   w_pc_src;
  logic                   w_load_in_e;
  logic                   w_rd_e_match;
  logic                   w_lw_stall;
  logic                   w_flush_e;

  assign w_ctrl_d = '{
    reg_write:  RegWriteD,
    mem_write:  MemWriteD,
    alu_src:    ALUSrcD,
    branch:     BranchD,
    jump:       JumpD,
    result_src: ResultSrcD,
    alu_op:     ALUOpD
  };

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign w_pc_src     = (r_ctrl_e.branch & ZeroE) | r_ctrl_e.jump;
  assign w_load_in_e  = (r_ctrl_e.result_src == RES_MEM) && (r_rd_e != '0);
  assign w_rd_e_match = (r_rd_e == Rs1D) || (r_rd_e == Rs2D);
  // A redirect squashes the decode instruction, so it never needs to wait
  assign w_lw_stall   = w_load_in_e && w_rd_e_match && !w_pc_src;
  assign w_flush_e    = w_lw_stall | w_pc_src;

  assign StallF = w_lw_stall;
  assign StallD = w_lw_stall;
  assign FlushD = w_pc_src;
  assign FlushE = w_flush_e;
  assign PCSrcE = w_pc_src;

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  forward_unit #(
    .REG_AW (REG_AW)
  ) u_forward_unit (
    .i_rs1_e       (r_rs1_e),
    .i_rs2_e       (r_rs2_e),
    .i_rd_m        (r_rd_m),
    .i_rd_w        (r_rd_w),
    .i_reg_write_m (r_reg_write_m),
    .i_reg_write_w (r_reg_write_w),
    .o_forward_a   (ForwardAE),
    .o_forward_b   (ForwardBE)
  );

  // ---------------------------------------------------------------------------
  // Pipeline registers. E never holds: a stall is turned into a bubble here
  // while the IF/ID registers are frozen upstream.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl_e <= CTRL_BUBBLE;
      r_rs1_e  <= '0;
      r_rs2_e  <= '0;
      r_rd_e   <= '0;
    end else if (w_flush_e) begin
      r_ctrl_e <= CTRL_BUBBLE;
      r_rs1_e  <= '0;
      r_rs2_e  <= '0;
      r_rd_e   <= '0;
    end else begin
      r_ctrl_e <= w_ctrl_d;
      r_rs1_e  <= Rs1D;
      r_rs2_e  <= Rs2D;
      r_rd_e   <= RdD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= RES_ALU;
      r_rd_m         <= '0;
      r_reg_write_w  <= 1'b0;
      r_result_src_w <= RES_ALU;
      r_rd_w         <= '0;
    end else begin
      r_reg_write_m  <= r_ctrl_e.reg_write;
      r_mem_write_m  <= r_ctrl_e.mem_write;
      r_result_src_m <= r_ctrl_e.result_src;
      r_rd_m         <= r_rd_e;
      r_reg_write_w  <= r_reg_write_m;
      r_result_src_w <= r_result_src_m;
      r_rd_w         <= r_rd_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating event counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_lw_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (w_pc_src && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign RegWriteE  = r_ctrl_e.reg_write;
  assign MemWriteE  = r_ctrl_e.mem_write;
  assign ALUSrcE    = r_ctrl_e.alu_src;
  assign BranchE    = r_ctrl_e.branch;
  assign JumpE      = r_ctrl_e.jump;
  assign ResultSrcE = r_ctrl_e.result_src;
  assign ALUOpE     = r_ctrl_e.alu_op;

  assign RegWriteM  = r_reg_write_m;
  assign MemWriteM  = r_mem_write_m;
  assign ResultSrcM = r_result_src_m;

  assign RegWriteW  = r_reg_write_w;
  assign ResultSrcW = r_result_src_w;

  assign Rs1E       = r_rs1_e;
  assign Rs2E       = r_rs2_e;
  assign RdE        = r_rd_e;
  assign RdM        = r_rd_m;
  assign RdW        = r_rd_w;

  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_control.sv
module tb_pipeline_control;

  localparam int VW = 86;

  logic       clk;
  logic       reset;
  logic       RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD, ZeroE;
  logic [1:0] ResultSrcD, ALUOpD;
  logic [4:0] Rs1D, Rs2D, RdD;

  // main instance (16-bit counters)
  logic       StallF, StallD, FlushD, FlushE, PCSrcE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [1:0] ResultSrcE, ALUOpE;
  logic       RegWriteM, MemWriteM;
  logic [1:0] ResultSrcM;
  logic       RegWriteW;
  logic [1:0] ResultSrcW;
  logic [4:0] Rs1E, Rs2E, RdE, RdM, RdW;
  logic [15:0] stall_cnt, flush_cnt;

  // narrow-counter instance (2-bit counters) sharing the same inputs
  logic       StallF_s, StallD_s, FlushD_s, FlushE_s, PCSrcE_s;
  logic [1:0] ForwardAE_s, ForwardBE_s;
  logic       RegWriteE_s, MemWriteE_s, ALUSrcE_s, BranchE_s, JumpE_s;
  logic [1:0] ResultSrcE_s, ALUOpE_s;
  logic       RegWriteM_s, MemWriteM_s;
  logic [1:0] ResultSrcM_s;
  logic       RegWriteW_s;
  logic [1:0] ResultSrcW_s;
  logic [4:0] Rs1E_s, Rs2E_s, RdE_s, RdM_s, RdW_s;
  logic [1:0] stall_cnt_s, flush_cnt_s;

  int errors = 0;
  int checks = 0;

  pipeline_control #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
    .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD), .ALUOpD(ALUOpD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCSrcE(PCSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE), .ALUOpE(ALUOpE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_control #(.REG_AW(5), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
    .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD), .ALUOpD(ALUOpD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
    .StallF(StallF_s), .StallD(StallD_s), .FlushD(FlushD_s), .FlushE(FlushE_s),
    .PCSrcE(PCSrcE_s), .ForwardAE(ForwardAE_s), .ForwardBE(ForwardBE_s),
    .RegWriteE(RegWriteE_s), .MemWriteE(MemWriteE_s), .ALUSrcE(ALUSrcE_s),
    .BranchE(BranchE_s), .JumpE(JumpE_s), .ResultSrcE(ResultSrcE_s), .ALUOpE(ALUOpE_s),
    .RegWriteM(RegWriteM_s), .MemWriteM(MemWriteM_s), .ResultSrcM(ResultSrcM_s),
    .RegWriteW(RegWriteW_s), .ResultSrcW(ResultSrcW_s),
    .Rs1E(Rs1E_s), .Rs2E(Rs2E_s), .RdE(RdE_s), .RdM(RdM_s), .RdW(RdW_s),
    .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: each pipeline slot holds a whole instruction record.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       rw, mw, as, br, jp;
    logic [1:0] rs, ao;
    logic [4:0] r1, r2, rd;
  } inst_t;

  inst_t m_e = '0, m_m = '0, m_w = '0;
  int m_sc = 0, m_fc = 0, m_sc2 = 0, m_fc2 = 0;

  function automatic inst_t cur_d();
    inst_t d;
    d = '{rw: RegWriteD, mw: MemWriteD, as: ALUSrcD, br: BranchD, jp: JumpD,
          rs: ResultSrcD, ao: ALUOpD, r1: Rs1D, r2: Rs2D, rd: RdD};
    return d;
  endfunction

  function automatic bit m_redirect();
    return (m_e.br && ZeroE) || m_e.jp;
  endfunction

  function automatic bit m_loaduse();
    return (m_e.rs == 2'b01) && (m_e.rd != 0) &&
           ((m_e.rd == Rs1D) || (m_e.rd == Rs2D)) && !m_redirect();
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (m_m.rw && m_m.rd != 0 && m_m.rd == src) return 2'b10;
    if (m_w.rw && m_w.rd != 0 && m_w.rd == src) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_e <= '0; m_m <= '0; m_w <= '0;
      m_sc <= 0; m_fc <= 0; m_sc2 <= 0; m_fc2 <= 0;
    end else begin
      m_e <= (m_loaduse() || m_redirect()) ? inst_t'('0) : cur_d();
      m_m <= m_e;
      m_w <= m_m;
      if (m_loaduse()) begin
        m_sc  <= (m_sc  < 65535) ? m_sc + 1  : m_sc;
        m_sc2 <= (m_sc2 < 3)     ? m_sc2 + 1 : m_sc2;
      end
      if (m_redirect()) begin
        m_fc  <= (m_fc  < 65535) ? m_fc + 1  : m_fc;
        m_fc2 <= (m_fc2 < 3)     ? m_fc2 + 1 : m_fc2;
      end
    end
  end

  function automatic logic [VW-1:0] exp_vec();
    bit pc, lw;
    pc = m_redirect();
    lw = m_loaduse();
    return {lw, lw, pc, (lw | pc), pc, m_fwd(m_e.r1), m_fwd(m_e.r2),
            m_e.rw, m_e.mw, m_e.as, m_e.br, m_e.jp, m_e.rs, m_e.ao,
            m_m.rw, m_m.mw, m_m.rs, m_w.rw, m_w.rs,
            m_e.r1, m_e.r2, m_e.rd, m_m.rd, m_w.rd,
            16'(m_sc), 16'(m_fc), 2'(m_sc2), 2'(m_fc2)};
  endfunction

  logic [VW-1:0] act_vec;
  assign act_vec = {StallF, StallD, FlushD, FlushE, PCSrcE, ForwardAE, ForwardBE,
                    RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE, ALUOpE,
                    RegWriteM, MemWriteM, ResultSrcM, RegWriteW, ResultSrcW,
                    Rs1E, Rs2E, RdE, RdM, RdW,
                    stall_cnt, flush_cnt, stall_cnt_s, flush_cnt_s};

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all tasks start and end 1 time unit after a rising edge)
  // ---------------------------------------------------------------------------
  function automatic inst_t mk(input bit rw, input logic [1:0] rs, input bit br, input bit jp,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    inst_t d;
    d = '0;
    d.rw = rw; d.rs = rs; d.br = br; d.jp = jp; d.r1 = r1; d.r2 = r2; d.rd = rd;
    return d;
  endfunction

  task automatic drive_d(input inst_t d);
    RegWriteD = d.rw; MemWriteD = d.mw; ALUSrcD = d.as; BranchD = d.br; JumpD = d.jp;
    ResultSrcD = d.rs; ALUOpD = d.ao; Rs1D = d.r1; Rs2D = d.r2; RdD = d.rd;
  endtask

  task automatic push(input inst_t d);
    drive_d(d);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ZeroE = 1'b0;
    drive_d('0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_d(inst_t'({$urandom, $urandom}));
      ZeroE = 1'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (act_vec !== '0) begin
      errors++;
      $display("FAIL reset_all_zero: got %h expected 0", act_vec);
    end
    drive_d('0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(mk(1, 2'b00, 0, 0, 5'd1, 5'd2, 5'd3));
    push(mk(1, 2'b01, 0, 0, 5'd0, 5'd0, 5'd4));
    reset = 1'b1;
    drive_d(mk(1, 2'b00, 0, 0, 5'd0, 5'd0, 5'd9));
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({RegWriteE, RegWriteM, RegWriteW, MemWriteM} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_writes: got E/M/W/MW=%b expected 0000",
               {RegWriteE, RegWriteM, RegWriteW, MemWriteM});
    end
    reset = 1'b0;
    drive_d('0);
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    do_reset();
    push(mk(1, 2'b01, 0, 0, 5'd0, 5'd0, 5'd5));   // lw x5
    drive_d(mk(1, 2'b00, 0, 0, 5'd5, 5'd0, 5'd6)); // add x6, x5, x0
    @(negedge clk);
    checks++;
    if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
      errors++;
      $display("FAIL loaduse_stall: got F/D/FE/FD=%b expected 1110",
               {StallF, StallD, FlushE, FlushD});
    end
    @(posedge clk); #1;                             // D held by the stall
    @(negedge clk);
    checks++;
    if (ResultSrcE !== 2'b00 || RegWriteE !== 1'b0) begin
      errors++;
      $display("FAIL loaduse_bubble: got ResultSrcE=%b RegWriteE=%b expected 00/0",
               ResultSrcE, RegWriteE);
    end
    checks++;
    if (StallF !== 1'b0 || stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL loaduse_single: got StallF=%b stall_cnt=%0d expected 0/1",
               StallF, stall_cnt);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (RegWriteE !== 1'b1 || RdE !== 5'd6 || ForwardAE !== 2'b01) begin
      errors++;
      $display("FAIL loaduse_resume: got RegWriteE=%b RdE=%0d ForwardAE=%b expected 1/6/01",
               RegWriteE, RdE, ForwardAE);
    end
    drive_d('0);
    @(posedge clk); #1;
  endtask

  task automatic test_forwarding();
    do_reset();
    push(mk(1, 2'b00, 0, 0, 5'd0, 5'd0, 5'd7));
    push(mk(1, 2'b00, 0, 0, 5'd0, 5'd0, 5'd7));
    push(mk(0, 2'b00, 0, 0, 5'd7, 5'd0, 5'd0));
    @(negedge clk);
    checks++;
    if (ForwardAE !== 2'b10) begin
      errors++;
      $display("FAIL fwd_mem_priority: got %b expected 10", ForwardAE);
    end
    checks++;
    if (ForwardBE !== 2'b00) begin
      errors++;
      $display("FAIL fwd_b_x0: got %b expected 00", ForwardBE);
    end
    @(posedge clk); #1;

    do_reset();
    push(mk(1, 2'b00, 0, 0, 5'd0, 5'd0, 5'd7));
    push(mk(0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd7));
    push(mk(0, 2'b00, 0, 0, 5'd7, 5'd7, 5'd0));
    @(negedge clk);
    checks++;
    if (ForwardAE !== 2'b01 || ForwardBE !== 2'b01) begin
      errors++;
      $display("FAIL fwd_wb: got A=%b B=%b expected 01/01", ForwardAE, ForwardBE);
    end
    @(posedge clk); #1;

    // writes to x0 in both MEM and WB are never forwarded
    do_reset();
    push(mk(1, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0));
    push(mk(1, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0));
    push(mk(0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0));
    @(negedge clk);
    checks++;
    if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
      errors++;
      $display("FAIL fwd_x0: got A=%b B=%b expected 00/00", ForwardAE, ForwardBE);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_branch();
    do_reset();
    push(mk(0, 2'b00, 1, 0, 5'd1, 5'd2, 5'd0));   // beq in E next
    ZeroE = 1'b1;
    drive_d(mk(1, 2'b00, 0, 0, 5'd1, 5'd1, 5'd3));
    @(negedge clk);
    checks++;
    if ({PCSrcE, FlushD, FlushE, StallF} !== 4'b1110) begin
      errors++;
      $display("FAIL branch_taken: got PC/FD/FE/SF=%b expected 1110",
               {PCSrcE, FlushD, FlushE, StallF});
    end
    @(posedge clk); #1;
    ZeroE = 1'b0;
    @(negedge clk);
    checks++;
    if (RegWriteE !== 1'b0 || BranchE !== 1'b0 || RdE !== 5'd0 || flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL branch_flushed: got RegWriteE=%b BranchE=%b RdE=%0d flush_cnt=%0d expected 0/0/0/1",
               RegWriteE, BranchE, RdE, flush_cnt);
    end
    push(mk(0, 2'b00, 1, 0, 5'd1, 5'd2, 5'd0));
    ZeroE = 1'b0;
    drive_d(mk(1, 2'b00, 0, 0, 5'd1, 5'd1, 5'd3));
    @(negedge clk);
    checks++;
    if ({PCSrcE, FlushD, FlushE} !== 3'b000) begin
      errors++;
      $display("FAIL branch_not_taken: got PC/FD/FE=%b expected 000", {PCSrcE, FlushD, FlushE});
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (RegWriteE !== 1'b1 || RdE !== 5'd3 || flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL branch_fallthrough: got RegWriteE=%b RdE=%0d flush_cnt=%0d expected 1/3/1",
               RegWriteE, RdE, flush_cnt);
    end
    drive_d('0);
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous();
    do_reset();
    push(mk(1, 2'b01, 1, 0, 5'd0, 5'd0, 5'd5));   // load with branch bit set
    ZeroE = 1'b1;
    drive_d(mk(1, 2'b00, 0, 0, 5'd5, 5'd0, 5'd6));
    @(negedge clk);
    checks++;
    if ({StallF, StallD, FlushD, FlushE, PCSrcE} !== 5'b00111) begin
      errors++;
      $display("FAIL simul_redirect_wins: got SF/SD/FD/FE/PC=%b expected 00111",
               {StallF, StallD, FlushD, FlushE, PCSrcE});
    end
    @(posedge clk); #1;
    ZeroE = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL simul_counters: got stall=%0d flush=%0d expected 0/1", stall_cnt, flush_cnt);
    end
    drive_d('0);
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    int exp_s;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(mk(1, 2'b01, 0, 0, 5'd0, 5'd0, 5'd5));  // lw x5
      push(mk(1, 2'b00, 0, 0, 5'd5, 5'd5, 5'd6));  // stall cycle
      exp_s = (i + 1 > 3) ? 3 : i + 1;
      @(negedge clk);
      checks++;
      if (stall_cnt_s !== 2'(exp_s) || stall_cnt !== 16'(i + 1)) begin
        errors++;
        $display("FAIL stall_saturate[%0d]: got narrow=%0d wide=%0d expected %0d/%0d",
                 i, stall_cnt_s, stall_cnt, exp_s, i + 1);
      end
      push(mk(1, 2'b00, 0, 0, 5'd5, 5'd5, 5'd6));  // add enters E
    end
    drive_d('0);
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      inst_t d;
      reset = ($urandom_range(0, 63) == 0);
      d = inst_t'({$urandom, $urandom});
      d.r1 = 5'($urandom_range(0, 3));
      d.r2 = 5'($urandom_range(0, 3));
      d.rd = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) d.rs = 2'b01;
      d.br = ($urandom_range(0, 4) == 0);
      d.jp = ($urandom_range(0, 9) == 0);
      drive_d(d);
      ZeroE = 1'($urandom);
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", n, act_vec, exp_vec());
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ZeroE = 1'b0;
    drive_d('0);
    @(posedge clk); #1;
    test_reset();
    test_reset_mid();
    test_load_use();
    test_forwarding();
    test_branch();
    test_simultaneous();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
